acq_trig_sequencer: RTL and testbench

//  Owns the fill-type enables and trigger input of the ADC acquisition state machine, in the ADC clock domain.

---
 rtl/acq_trig_sequencer.sv | 260 ++++++++++++++++++++++++++
 tb/tb_acq_trig_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acq_trig_sequencer.sv
`default_nettype none
// =============================================================================
// Module   : acq_trig_sequencer
// Purpose  : Queues ADC fill requests and runs them one at a time against the
//            acquisition state machine: drive enables, raise trigger, wait for
//            done, return enables to readout mode and hold an inter-fill gap.
// Options  : ACQ_SEQ_TIMEOUT_EN - adds the trigger-to-done watchdog, the ABORT
//            recovery path, the acq_reset pulse and the sticky timeout_err.
// Revision : 1.0 - initial release
// =============================================================================
module acq_trig_sequencer #(
    parameter int QDEPTH_LOG2  = 2,
    parameter int SETUP_CYCLES = 6,
    parameter int GAP_CYCLES   = 16,
    parameter int RST_CYCLES   = 8,
    parameter int TO_W         = 24
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 trig_req,
    input  logic [1:0]           trig_fill_type,
    input  logic                 acq_arm,
    input  logic [TO_W-1:0]      timeout_cycles,
    input  logic                 clear_err,
    input  logic                 acq_done,
    output logic                 acq_enable0,
    output logic                 acq_enable1,
    output logic                 acq_trig,
    output logic                 acq_reset,
    output logic                 busy,
    output logic [QDEPTH_LOG2:0] q_level,
    output logic [31:0]          fill_count,
    output logic [15:0]          drop_count,
    output logic                 timeout_err
);

    localparam int QDEPTH = 1 << QDEPTH_LOG2;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_TRIG    = 3'd2;
    localparam logic [2:0] S_RELEASE = 3'd3;
    localparam logic [2:0] S_ABORT   = 3'd4;
    localparam logic [2:0] S_GAP     = 3'd5;

    logic [2:0]             state_q, state_d;
    logic [1:0]             ftype_q, ftype_d;
    logic [15:0]            phase_q, phase_d;
    logic [1:0]             mem_q [QDEPTH];
    logic [1:0]             mem_d [QDEPTH];
    logic [QDEPTH_LOG2-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [QDEPTH_LOG2:0]   lvl_q, lvl_d;
    logic                   arm_q, arm_d;
    logic [1:0]             en_q, en_d;
    logic                   trig_q, trig_d;
    logic                   busy_q, busy_d;
    logic [31:0]            fill_count_q, fill_count_d;
    logic [15:0]            drop_count_q, drop_count_d;

    logic q_full, q_empty, flush, push, drop, pop, fill_inc, to_hit;

    // Request acceptance uses the registered (pre-pop) occupancy
    assign q_full  = (lvl_q == (QDEPTH_LOG2+1)'(QDEPTH));
    assign q_empty = (lvl_q == '0);
    assign flush   = arm_q & ~acq_arm;
    assign push    = trig_req & acq_arm & (trig_fill_type != 2'b00) & ~q_full;
    assign drop    = trig_req & ~push;
    assign arm_d   = acq_arm;

    // Fill sequencing: pop, setup, trigger, release/abort, gap
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        ftype_d  = ftype_q;
        pop      = 1'b0;
        fill_inc = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A flush in this cycle wins over starting a new fill
                if (!q_empty && !flush) begin
                    pop     = 1'b1;
                    ftype_d = mem_q[rd_q];
                    state_d = S_SETUP;
                    phase_d = '0;
                end
            end
            S_SETUP: begin
                if (phase_q == 16'(SETUP_CYCLES - 1)) begin
                    state_d = S_TRIG;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 16'd1;
                end
            end
            S_TRIG: begin
                if (acq_done) begin
                    fill_inc = 1'b1;
                    state_d  = S_RELEASE;
                end else if (to_hit) begin
                    state_d = S_ABORT;
                    phase_d = '0;
                end
            end
            S_RELEASE: begin
                if (!acq_done) begin
                    state_d = S_GAP;
                    phase_d = '0;
                end
            end
            S_ABORT: begin
                if (phase_q == 16'(RST_CYCLES - 1)) begin
                    state_d = S_GAP;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 16'd1;
                end
            end
            S_GAP: begin
                if (phase_q == 16'(GAP_CYCLES - 1)) begin
                    state_d = S_IDLE;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                phase_d = '0;
            end
        endcase
    end

    // Circular request queue with flush on the falling edge of acq_arm
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        lvl_d = lvl_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            lvl_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q] = trig_fill_type;
                wr_d        = wr_q + 1'b1;
            end
            if (pop) begin
                rd_d = rd_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   lvl_d = lvl_q + 1'b1;
                2'b01:   lvl_d = lvl_q - 1'b1;
                default: lvl_d = lvl_q;
            endcase
        end
    end

    // Next-cycle output values, derived from next state so every output is a flop
    always_comb begin
        en_d         = (state_d == S_SETUP || state_d == S_TRIG || state_d == S_RELEASE)
                       ? ftype_d : 2'b00;
        trig_d       = (state_d == S_TRIG);
        busy_d       = (state_d != S_IDLE) || (lvl_d != '0);
        fill_count_d = fill_count_q + {31'd0, fill_inc};
        drop_count_d = (drop && drop_count_q != 16'hFFFF) ? drop_count_q + 16'd1 : drop_count_q;
    end

    // State, queue and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            ftype_q      <= 2'b00;
            phase_q      <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= 2'b00;
            end
            wr_q         <= '0;
            rd_q         <= '0;
            lvl_q        <= '0;
            arm_q        <= 1'b0;
            en_q         <= 2'b00;
            trig_q       <= 1'b0;
            busy_q       <= 1'b0;
            fill_count_q <= '0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            ftype_q      <= ftype_d;
            phase_q      <= phase_d;
            mem_q        <= mem_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            lvl_q        <= lvl_d;
            arm_q        <= arm_d;
            en_q         <= en_d;
            trig_q       <= trig_d;
            busy_q       <= busy_d;
            fill_count_q <= fill_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign acq_enable0 = en_q[0];
    assign acq_enable1 = en_q[1];
    assign acq_trig    = trig_q;
    assign busy        = busy_q;
    assign q_level     = lvl_q;
    assign fill_count  = fill_count_q;
    assign drop_count  = drop_count_q;

`ifdef ACQ_SEQ_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_q, to_cnt_d, to_cnt_inc;
    logic            acq_reset_q, acq_reset_d;
    logic            timeout_err_q, timeout_err_d;

    // Watchdog fires when the count since trigger rise reaches timeout_cycles
    assign to_cnt_inc = to_cnt_q + 1'b1;
    assign to_hit     = (state_q == S_TRIG) && (timeout_cycles != '0) &&
                        (to_cnt_inc == timeout_cycles);

    // Watchdog count, reset pulse and sticky error (set beats clear)
    always_comb begin
        to_cnt_d    = (state_q == S_TRIG) ? to_cnt_inc : '0;
        acq_reset_d = (state_d == S_ABORT);
        if (state_q == S_TRIG && state_d == S_ABORT) begin
            timeout_err_d = 1'b1;
        end else if (clear_err) begin
            timeout_err_d = 1'b0;
        end else begin
            timeout_err_d = timeout_err_q;
        end
    end

    // Timeout registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt_q      <= '0;
            acq_reset_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            to_cnt_q      <= to_cnt_d;
            acq_reset_q   <= acq_reset_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign acq_reset   = acq_reset_q;
    assign timeout_err = timeout_err_q;
`else
    logic unused_timeout_inputs;

    assign to_hit                = 1'b0;
    assign acq_reset             = 1'b0;
    assign timeout_err           = 1'b0;
    assign unused_timeout_inputs = ^{timeout_cycles, clear_err};
`endif

endmodule
`default_nettype wire

// File: tb/tb_acq_trig_sequencer.sv
`default_nettype none
// =============================================================================
// Module   : tb_acq_trig_sequencer
// Purpose  : Self-checking bench for acq_trig_sequencer: request-acceptance
//            vector table, latency / done-handshake / async-reset sequences,
//            randomized traffic against a schedule-based reference model, and
//            (with ACQ_SEQ_TIMEOUT_EN) the timeout recovery path.
// Revision : 1.0 - initial release
// =============================================================================
module tb_acq_trig_sequencer;

    localparam int SETUP = 6;
    localparam int GAP   = 16;
    localparam int QD    = 4;

    logic        clk            = 1'b0;
    logic        reset_n        = 1'b0;
    logic        trig_req       = 1'b0;
    logic [1:0]  trig_fill_type = 2'b00;
    logic        acq_arm        = 1'b0;
    logic [23:0] timeout_cycles = 24'd0;
    logic        clear_err      = 1'b0;
    logic        acq_done       = 1'b0;
    logic        acq_enable0, acq_enable1, acq_trig, acq_reset, busy, timeout_err;
    logic [2:0]  q_level;
    logic [31:0] fill_count;
    logic [15:0] drop_count;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    acq_trig_sequencer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .trig_req       (trig_req),
        .trig_fill_type (trig_fill_type),
        .acq_arm        (acq_arm),
        .timeout_cycles (timeout_cycles),
        .clear_err      (clear_err),
        .acq_done       (acq_done),
        .acq_enable0    (acq_enable0),
        .acq_enable1    (acq_enable1),
        .acq_trig       (acq_trig),
        .acq_reset      (acq_reset),
        .busy           (busy),
        .q_level        (q_level),
        .fill_count     (fill_count),
        .drop_count     (drop_count),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        trig_req       = 1'b0;
        trig_fill_type = 2'b00;
        acq_arm        = 1'b0;
        acq_done       = 1'b0;
        clear_err      = 1'b0;
        timeout_cycles = 24'd0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        cyc     = 0;
    endtask

    task automatic wait_trig(input int limit, input string name);
        int n = 0;
        while (acq_trig !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        tests++;
        if (acq_trig !== 1'b1) begin
            fails++;
            $display("FAIL %s: acq_trig got 0 after %0d cycles, expected 1", name, limit);
        end
    endtask

    // Acceptance vectors: inputs driven for one cycle, outputs checked the next
    typedef struct {
        logic        req;
        logic [1:0]  ty;
        logic        arm;
        logic [2:0]  lvl;
        logic [15:0] drop;
        logic        busy;
        logic [1:0]  en;
        logic        trig;
    } vec_t;
    vec_t tbl [12];

    // Reference model: request queue plus arithmetic timeline of the active fill
    int         mq[$];
    int         idle_from, mp, mt, mn, mh, exp_fill, exp_drop, t0;
    logic       mvalid, prev_arm, m_flush, m_push, m_pop;
    logic [1:0] mft, e_en;
    logic       e_trig, e_busy;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 2'b00, 1'b1, 3'd0, 16'd1, 1'b0, 2'b00, 1'b0};
        tbl[1]  = '{1'b1, 2'b10, 1'b0, 3'd0, 16'd2, 1'b0, 2'b00, 1'b0};
        tbl[2]  = '{1'b0, 2'b00, 1'b1, 3'd0, 16'd2, 1'b0, 2'b00, 1'b0};
        tbl[3]  = '{1'b1, 2'b01, 1'b1, 3'd1, 16'd2, 1'b1, 2'b00, 1'b0};
        tbl[4]  = '{1'b1, 2'b10, 1'b1, 3'd1, 16'd2, 1'b1, 2'b01, 1'b0};
        tbl[5]  = '{1'b1, 2'b11, 1'b1, 3'd2, 16'd2, 1'b1, 2'b01, 1'b0};
        tbl[6]  = '{1'b1, 2'b01, 1'b1, 3'd3, 16'd2, 1'b1, 2'b01, 1'b0};
        tbl[7]  = '{1'b1, 2'b10, 1'b1, 3'd4, 16'd2, 1'b1, 2'b01, 1'b0};
        tbl[8]  = '{1'b1, 2'b11, 1'b1, 3'd4, 16'd3, 1'b1, 2'b01, 1'b0};
        tbl[9]  = '{1'b1, 2'b11, 1'b1, 3'd4, 16'd4, 1'b1, 2'b01, 1'b0};
        tbl[10] = '{1'b0, 2'b00, 1'b0, 3'd0, 16'd4, 1'b1, 2'b01, 1'b1};
        tbl[11] = '{1'b0, 2'b00, 1'b1, 3'd0, 16'd4, 1'b1, 2'b01, 1'b1};

        // ---------------- reset state + acceptance table ----------------
        do_reset();
        check("rst_en",    32'({acq_enable1, acq_enable0}), 32'd0);
        check("rst_trig",  32'(acq_trig), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_level", 32'(q_level), 32'd0);
        check("rst_fills", fill_count, 32'd0);
        check("rst_drops", 32'(drop_count), 32'd0);
        check("rst_areset", 32'(acq_reset), 32'd0);
        check("rst_err",   32'(timeout_err), 32'd0);
        for (int i = 0; i < 12; i++) begin
            trig_req       = tbl[i].req;
            trig_fill_type = tbl[i].ty;
            acq_arm        = tbl[i].arm;
            tick();
            check($sformatf("tbl%0d_level", i), 32'(q_level), 32'(tbl[i].lvl));
            check($sformatf("tbl%0d_drops", i), 32'(drop_count), 32'(tbl[i].drop));
            check($sformatf("tbl%0d_busy", i),  32'(busy), 32'(tbl[i].busy));
            check($sformatf("tbl%0d_en", i),    32'({acq_enable1, acq_enable0}), 32'(tbl[i].en));
            check($sformatf("tbl%0d_trig", i),  32'(acq_trig), 32'(tbl[i].trig));
        end
        trig_req = 1'b0;
        acq_done = 1'b1;
        tick();
        acq_done = 1'b0;
        check("flush_fill_done_trig", 32'(acq_trig), 32'd0);
        check("flush_fill_count", fill_count, 32'd1);
        for (int n = 0; n < 40 && busy === 1'b1; n++) tick();
        check("flush_idle_busy",  32'(busy), 32'd0);
        check("flush_idle_level", 32'(q_level), 32'd0);
        check("flush_idle_fills", fill_count, 32'd1);

        // ---------------- single-fill latency and done handshake ----------------
        do_reset();
        acq_arm        = 1'b1;
        trig_req       = 1'b1;
        trig_fill_type = 2'b01;
        tick();                                   // cycle 1
        trig_req = 1'b0;
        check("lat_c1_en",   32'({acq_enable1, acq_enable0}), 32'd0);
        check("lat_c1_busy", 32'(busy), 32'd1);
        tick();                                   // cycle 2
        check("lat_c2_en",   32'({acq_enable1, acq_enable0}), 32'd1);
        while (cyc < 7) tick();
        check("lat_c7_trig", 32'(acq_trig), 32'd0);
        tick();                                   // cycle 8
        check("lat_c8_trig", 32'(acq_trig), 32'd1);
        check("lat_c8_en",   32'({acq_enable1, acq_enable0}), 32'd1);
        while (cyc < 28) tick();
        acq_done = 1'b1;
        check("lat_c28_trig", 32'(acq_trig), 32'd1);
        tick();                                   // cycle 29
        check("lat_c29_trig",  32'(acq_trig), 32'd0);
        check("lat_c29_fills", fill_count, 32'd1);
        tick();                                   // cycle 30, done still held at 29
        acq_done = 1'b0;
        check("lat_c30_release_en", 32'({acq_enable1, acq_enable0}), 32'd1);
        tick();                                   // cycle 31, GAP
        check("lat_c31_gap_en",   32'({acq_enable1, acq_enable0}), 32'd0);
        check("lat_c31_gap_busy", 32'(busy), 32'd1);
        while (cyc < 46) tick();
        check("lat_c46_busy", 32'(busy), 32'd1);
        tick();
        check("lat_c47_busy", 32'(busy), 32'd0);

        // ---------------- asynchronous reset during TRIG ----------------
        trig_req       = 1'b1;
        trig_fill_type = 2'b11;
        tick();
        trig_fill_type = 2'b01;
        tick();
        trig_req = 1'b0;
        wait_trig(30, "arst_wait_trig");
        check("arst_pre_level", 32'(q_level), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_en",    32'({acq_enable1, acq_enable0}), 32'd0);
        check("arst_trig",  32'(acq_trig), 32'd0);
        check("arst_busy",  32'(busy), 32'd0);
        check("arst_level", 32'(q_level), 32'd0);
        check("arst_fills", fill_count, 32'd0);
        @(negedge clk);

        // ---------------- randomized traffic vs reference model ----------------
        do_reset();
        mq.delete();
        idle_from = 0;
        mvalid    = 1'b0;
        exp_fill  = 0;
        exp_drop  = 0;
        prev_arm  = 1'b0;
        mp = 0; mt = 0; mn = 0; mh = 0; mft = 2'b00;
        acq_arm   = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if (mvalid && cyc == mt + mn + 1) exp_fill++;
            e_en   = (mvalid && cyc >= mp + 1 && cyc <= mt + mn + mh) ? mft : 2'b00;
            e_trig = mvalid && cyc >= mt && cyc <= mt + mn;
            e_busy = (cyc < idle_from) || (mq.size() != 0);
            check("rnd_en",    32'({acq_enable1, acq_enable0}), 32'(e_en));
            check("rnd_trig",  32'(acq_trig), 32'(e_trig));
            check("rnd_busy",  32'(busy), 32'(e_busy));
            check("rnd_level", 32'(q_level), 32'(mq.size()));
            check("rnd_fills", fill_count, 32'(exp_fill));
            check("rnd_drops", 32'(drop_count), 32'(exp_drop));
            check("rnd_areset", 32'(acq_reset), 32'd0);
            check("rnd_err",   32'(timeout_err), 32'd0);

            if (acq_arm) acq_arm = ($urandom_range(0, 59) != 0);
            else         acq_arm = ($urandom_range(0, 3) == 0);
            trig_req       = ($urandom_range(0, 2) == 0);
            trig_fill_type = 2'($urandom_range(0, 3));
            acq_done       = mvalid && cyc >= mt + mn && cyc <= mt + mn + mh - 1;

            m_flush = prev_arm && !acq_arm;
            m_push  = trig_req && acq_arm && (trig_fill_type != 2'b00) && (mq.size() < QD);
            if (trig_req && !m_push) exp_drop++;
            m_pop = (cyc >= idle_from) && (mq.size() > 0) && !m_flush;
            if (m_pop) begin
                mft       = 2'(mq.pop_front());
                mp        = cyc;
                mt        = cyc + 1 + SETUP;
                mn        = $urandom_range(0, 20);
                mh        = $urandom_range(1, 12);
                idle_from = mt + mn + mh + 1 + GAP;
                mvalid    = 1'b1;
            end
            if (m_flush) mq.delete();
            if (m_push)  mq.push_back(int'(trig_fill_type));
            prev_arm = acq_arm;
            tick();
        end
        trig_req = 1'b0;
        acq_done = 1'b0;

`ifdef ACQ_SEQ_TIMEOUT_EN
        // ---------------- timeout, abort pulse, clear, next fill ----------------
        do_reset();
        timeout_cycles = 24'd100;
        acq_arm        = 1'b1;
        trig_req       = 1'b1;
        trig_fill_type = 2'b10;
        tick();
        trig_fill_type = 2'b11;
        tick();
        trig_req = 1'b0;
        wait_trig(20, "to_first_trig");
        t0 = cyc;
        check("to_trig_cycle", 32'(t0), 32'd8);
        while (cyc < t0 + 99) tick();
        check("to_t99_trig",   32'(acq_trig), 32'd1);
        check("to_t99_areset", 32'(acq_reset), 32'd0);
        tick();
        check("to_t100_trig",   32'(acq_trig), 32'd0);
        check("to_t100_areset", 32'(acq_reset), 32'd1);
        check("to_t100_err",    32'(timeout_err), 32'd1);
        check("to_t100_en",     32'({acq_enable1, acq_enable0}), 32'd0);
        while (cyc < t0 + 107) tick();
        check("to_t107_areset", 32'(acq_reset), 32'd1);
        tick();
        check("to_t108_areset", 32'(acq_reset), 32'd0);
        check("to_t108_err",    32'(timeout_err), 32'd1);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("to_cleared_err", 32'(timeout_err), 32'd0);
        wait_trig(60, "to_next_trig");
        check("to_next_en",    32'({acq_enable1, acq_enable0}), 32'd3);
        check("to_next_level", 32'(q_level), 32'd0);
        acq_done = 1'b1;
        tick();
        acq_done = 1'b0;
        check("to_next_fills", fill_count, 32'd1);
`else
        // ---------------- without the watchdog TRIG waits for done ----------------
        do_reset();
        timeout_cycles = 24'd5;
        acq_arm        = 1'b1;
        trig_req       = 1'b1;
        trig_fill_type = 2'b10;
        tick();
        trig_req = 1'b0;
        wait_trig(20, "nto_trig");
        repeat (60) tick();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("nto_trig_held", 32'(acq_trig), 32'd1);
        check("nto_en_held",   32'({acq_enable1, acq_enable0}), 32'd2);
        check("nto_areset",    32'(acq_reset), 32'd0);
        check("nto_err",       32'(timeout_err), 32'd0);
        acq_done = 1'b1;
        tick();
        acq_done = 1'b0;
        check("nto_fills", fill_count, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
